// File: rtl/sw_ctrl_pkg.sv
// Shared types and constants for the stopwatch button front-end.
// Holds the FSM state encoding and the counter width helper.
package sw_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LAP  = 2'b10,
    STOP = 2'b11
  } sw_state_e;

  localparam int unsigned DEB_CYCLES_DEF = 500000;

  function automatic int unsigned cnt_w(
    input int unsigned n
  );
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-flop synchroniser, counter debouncer
// and a one-cycle pulse on the debounced rising edge.
module btn_debounce
  import sw_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned W = cnt_w(DEB_CYCLES);
  localparam logic [W-1:0] LAST = W'(DEB_CYCLES - 1);

  logic         s1;
  logic         s2;
  logic         lvl_d;
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl_d <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      lvl_d <= level;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~lvl_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/lap/stop/clear controller with debounced buttons.
// Define SW_LONG_CLEAR_EN to add long-press-start/stop clear.
module stopwatch_ctrl
  import sw_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lap,
  output logic       run,
  output logic       pause,
  output logic       clear,
  output logic [1:0] state
);

  sw_state_e st_q;
  sw_state_e st_d;
  logic      clr_q;
  logic      clr_d;
  logic      ss_lvl;
  logic      ss_p;
  logic      lap_lvl;
  logic      lap_p;
  logic      long_hit;
  logic      lap_unused;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_ss (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_ss),
    .level(ss_lvl),
    .press(ss_p)
  );

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_lap (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_lap),
    .level(lap_lvl),
    .press(lap_p)
  );

  assign lap_unused = lap_lvl;

`ifdef SW_LONG_CLEAR_EN
  localparam int unsigned HW = cnt_w(LONG_CYCLES);
  localparam logic [HW-1:0] HLAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hold_q;
  logic          hold_done;

  // saturates at HLAST; hold_done keeps it to one clear per hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q    <= '0;
      hold_done <= 1'b0;
    end else if (!ss_lvl) begin
      hold_q    <= '0;
      hold_done <= 1'b0;
    end else begin
      if (hold_q != HLAST) hold_q <= hold_q + 1'b1;
      if (long_hit)        hold_done <= 1'b1;
    end
  end

  assign long_hit = ss_lvl & (hold_q == HLAST) & ~hold_done;
`else
  logic cfg_unused;

  assign long_hit   = 1'b0;
  assign cfg_unused = ss_lvl ^ LONG_CYCLES[0];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= IDLE;
      clr_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      clr_q <= clr_d;
    end
  end

  // ss has priority over lap when both pulse together
  always_comb begin
    st_d  = st_q;
    clr_d = 1'b0;
    if (long_hit) begin
      st_d  = IDLE;
      clr_d = 1'b1;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (ss_p) st_d = RUN;
        end
        RUN: begin
          if (ss_p)       st_d = STOP;
          else if (lap_p) st_d = LAP;
        end
        LAP: begin
          if (ss_p)       st_d = STOP;
          else if (lap_p) st_d = RUN;
        end
        STOP: begin
          if (ss_p) begin
            st_d = RUN;
          end else if (lap_p) begin
            st_d  = IDLE;
            clr_d = 1'b1;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_comb begin
    run   = 1'b0;
    pause = 1'b0;
    unique case (1'b1)
      (st_q == RUN): run = 1'b1;
      (st_q == LAP): begin
        run   = 1'b1;
        pause = 1'b1;
      end
      default: ;
    endcase
  end

  assign clear = clr_q;
  assign state = st_q;

endmodule
